// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// DIGIT_SERIAL_ADDER_SUB_EN adds a subtract-mode input to the top.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int ndig_f(input int w, input int d);
    return w / d;
  endfunction

  function automatic int cnt_w_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder slice.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o
);

  logic cy;

  always_comb begin
    cy  = c_i;
    s_o = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ cy;
      cy     = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
    end
    c_o = cy;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: DIGIT bits per cycle, valid/ready on both sides.
// DIGIT_SERIAL_ADDER_SUB_EN adds a 'sub' port (a - b when set).
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NDIG = ndig_f(WIDTH, DIGIT);
  localparam int CW   = cnt_w_f(NDIG);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dsum;
  logic             dcar;
  logic [WIDTH-1:0] acc_sh;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             last;

  // Subtraction is folded in at capture: store ~b, force carry to 1.
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_add (
    .a_i(a_q[DIGIT-1:0]),
    .b_i(b_q[DIGIT-1:0]),
    .c_i(carry_q),
    .s_o(dsum),
    .c_o(dcar)
  );

  assign acc_sh = (acc_q >> DIGIT)
                | (WIDTH'(dsum) << (WIDTH - DIGIT));
  assign last   = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b_in;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_sh;
        carry_d = dcar;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d   = acc_sh;
          cout_d  = dcar;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and random checks for digit_serial_adder (DIGIT=4 and DIGIT=16).
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, cout;
  logic        sub_i;
  logic        x_in_valid, x_in_ready, x_out_valid, x_out_ready;
  logic [15:0] x_a, x_b, x_sum;
  logic        x_cin, x_cout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut_x (
    .clk(clk), .rst_n(rst_n),
    .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    .sub(sub_i),
`endif
    .out_valid(x_out_valid), .out_ready(x_out_ready),
    .sum(x_sum), .cout(x_cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, output logic [15:0] os,
                        output logic oc, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib; cin = ic;
    @(negedge clk);
    in_valid = 1'b0; a = ~ia; b = ~ib; cin = ~ic;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    os = sum; oc = cout;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_x(input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, output logic [15:0] os,
                       output logic oc, output int lat);
    @(negedge clk);
    x_in_valid = 1'b1; x_a = ia; x_b = ib; x_cin = ic;
    @(negedge clk);
    x_in_valid = 1'b0; x_a = ~ia; x_b = ~ib; x_cin = ~ic;
    lat = 1;
    while (!x_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    os = x_sum; oc = x_cout;
    x_out_ready = 1'b1;
    @(negedge clk);
    x_out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rs;
    logic        rc;
    int          lat;
    logic [16:0] q[$];
    logic [16:0] e;
    bit          busy;
    bit          seen;
    int          done_ops;
    int          cyc;

    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vt[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vt[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vt[6] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};
    vt[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    vt[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vt[9] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    x_in_valid = 1'b0; x_out_ready = 1'b0;
    x_a = '0; x_b = '0; x_cin = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, rs, rc, lat);
      chk($sformatf("v%0d_sum", i), rs, vt[i].s);
      chk($sformatf("v%0d_cout", i), rc, vt[i].co);
      chk($sformatf("v%0d_lat", i), lat, 5);
      chk($sformatf("v%0d_idle_rdy", i), in_ready, 1'b1);
      chk($sformatf("v%0d_keep_sum", i), sum, vt[i].s);
      run_x(vt[i].a, vt[i].b, vt[i].cin, rs, rc, lat);
      chk($sformatf("x%0d_sum", i), rs, vt[i].s);
      chk($sformatf("x%0d_cout", i), rc, vt[i].co);
      chk($sformatf("x%0d_lat", i), lat, 2);
    end

    // Stalled consumer with in_valid held high as noise.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
    @(negedge clk);
    a = 16'h0000; b = 16'h0000; cin = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_lat", lat, 5);
    for (int i = 0; i < 10; i++) begin
      chk("stall_sum", sum, 16'h5556);
      chk("stall_cout", cout, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("stall_rdy_same_cyc", in_ready, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_rel_ready", in_ready, 1'b1);
    chk("stall_rel_valid", out_valid, 1'b0);
    chk("stall_keep_sum", sum, 16'h5556);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum, 16'h0000);
    chk("mid_rst_cout", cout, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_no_valid", seen, 1'b0);

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    sub_i = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, rs, rc, lat);
    chk("sub0_sum", rs, 16'hFFFE);
    chk("sub0_cout", rc, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, rs, rc, lat);
    chk("sub1_sum", rs, 16'h0002);
    chk("sub1_cout", rc, 1'b1);
    chk("sub1_lat", lat, 5);
    sub_i = 1'b0;
`endif

    busy = 1'b0;
    done_ops = 0;
    cyc = 0;
    while (done_ops < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      chk("rnd_in_ready", in_ready, {31'b0, !busy});
      if (out_valid) begin
        if (q.size() == 0) chk("rnd_spurious_valid", out_valid, 1'b0);
        else chk("rnd_result", {cout, sum}, q[0]);
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom_range(0, 1));
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
      sub_i = 1'($urandom_range(0, 1));
      if (sub_i) e = 17'(a) + 17'(~b) + 17'd1;
      else e = 17'(a) + 17'(b) + 17'(cin);
`else
      e = 17'(a) + 17'(b) + 17'(cin);
`endif
      if (in_valid && in_ready) begin
        q.push_back(e);
        busy = 1'b1;
      end
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        busy = 1'b0;
        done_ops++;
      end
    end
    chk("rnd_ops_done", done_ops, 1000);
    in_valid = 1'b0;
    out_ready = 1'b0;
    sub_i = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT, DIGIT >= 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operands a, b, cin presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry in.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of MSB.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; NDIG = WIDTH/DIGIT.
REQ-015 IDLE: in_ready=1, out_valid=0; in_valid=1 SHALL capture a, b into shift registers, carry register <= cin, digit counter <= 0, next state RUN.
REQ-016 RUN: in_ready=0; each cycle SHALL add DIGIT LSBs of a, b plus carry register, shift result digit into sum register from MSB end, update carry register, increment counter.
REQ-017 RUN SHALL last exactly NDIG cycles; after digit NDIG-1 next state DONE, cout <= final carry.
REQ-018 DONE: out_valid=1, in_ready=0; sum and cout SHALL be stable; out_ready=1 SHALL return to IDLE next cycle.
REQ-019 Latency: out_valid SHALL rise NDIG+1 cycles after the accepting edge; throughput one operation per NDIG+2 cycles with out_ready held 1.
REQ-020 in_valid in RUN/DONE SHALL be ignored; inputs a, b, cin SHALL be sampled only at acceptance.
REQ-021 Result SHALL equal (a + b + cin) mod 2^WIDTH, cout the bit WIDTH, with wrap-around silently.
REQ-022 sum, cout SHALL retain last result in IDLE until next DONE overwrites them.
REQ-023 DIGIT == WIDTH SHALL be legal: RUN lasts one cycle.
REQ-024 out_ready in IDLE or RUN SHALL have no effect.

Reset
REQ-025 rst_n=0 SHALL force state IDLE, sum=0, cout=0, out_valid=0, counter=0, carry register=0, asynchronously, in any state.
REQ-026 Reset during RUN SHALL abort the operation; no out_valid SHALL follow release.
REQ-027 After release in_ready SHALL be 1 in the first cycle.

Configuration
REQ-028 Macro DIGIT_SERIAL_ADDER_SUB_EN SHALL add input port sub (1 bit), sampled with operands.
REQ-029 With macro and sub=1: result SHALL be (a + ~b + 1) mod 2^WIDTH, cin ignored, cout=1 meaning no borrow; sub=0 behaves as REQ-021.
REQ-030 Without macro: no sub port, addition only, identical timing.

Structure
REQ-031 Package digit_serial_adder_pkg SHALL hold state enum type and NDIG/counter-width helper constants/functions.
REQ-032 Sub-module digit_adder SHALL be the combinational DIGIT-bit ripple carry adder (sum, carry out from two digits and carry in), instantiated once.
REQ-033 Counter width SHALL be clog2(NDIG), minimum 1.

Verification
REQ-034 WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, cin=0 -> out_valid 5 cycles after accept, sum=0x0000, cout=1.
REQ-035 a=0x1234, b=0x4321, cin=1, out_ready held 0 for 10 cycles -> sum=0x5556, cout=0 held stable, in_ready=0 until 1 cycle after out_ready=1.
REQ-036 Reset asserted at RUN cycle 2 -> outputs 0 immediately, IDLE after release, no out_valid.
REQ-037 DIGIT=16: a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, out_valid 2 cycles after accept.
REQ-038 DIGIT_SERIAL_ADDER_SUB_EN, sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-039 Random back-to-back (1000 ops, random out_ready) -> every result matches reference model, no accept outside IDLE.
